sprite_line_scheduler: RTL

- Per-scanline sprite scheduler. Shares one sprite bitmap ROM read port among NUM_SPRITES sprites.
- During horizontal blanking it scans all sprites against the next line, fetches row bitmaps for up to MAX_ACTIVE hits into slot registers, then drives `pix`/`drawing` for the pixel painter during active video.
- Sits between the VGA timing generator (`line`, `horiz_pos`, `vert_pos`) and the colour mux in `top`.

---
 rtl/sprite_line_scheduler.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans sprites in hblank, fetches row bitmaps into slots, paints during active video.
// Optional SPRITE_COLLISION_EN adds collision / collision_seen outputs.
module sprite_line_scheduler #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned MAX_ACTIVE  = 2,
    parameter int unsigned SPR_W       = 8,
    parameter int unsigned SPR_H       = 8,
    parameter int unsigned POS_W       = 11,
    parameter int unsigned ROM_AW      = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           line,
    input  logic [POS_W-1:0]               horiz_pos,
    input  logic [POS_W-1:0]               vert_pos,
    input  logic [NUM_SPRITES*POS_W-1:0]   spx_pos,
    input  logic [NUM_SPRITES*POS_W-1:0]   spy_pos,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    output logic                           rom_rd,
    output logic [ROM_AW-1:0]              rom_addr,
    input  logic [SPR_W-1:0]               rom_data,
    output logic                           pix,
    output logic                           drawing,
    output logic [$clog2(NUM_SPRITES)-1:0] sprite_id,
    output logic                           busy,
    output logic                           overflow
`ifdef SPRITE_COLLISION_EN
    ,
    output logic                           collision,
    output logic                           collision_seen
`endif
);

    localparam int unsigned IDX_W  = $clog2(NUM_SPRITES);
    localparam int unsigned FILL_W = $clog2(MAX_ACTIVE + 1);
    localparam int unsigned ROW_W  = $clog2(SPR_H);
    localparam int unsigned OFF_W  = $clog2(SPR_W);
    localparam int unsigned EXT_W  = POS_W + 1;

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, LOAD} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [EXT_W-1:0]        target_q, target_d;
    logic                    rom_rd_q, rom_rd_d;
    logic [ROM_AW-1:0]       rom_addr_q, rom_addr_d;
    logic                    overflow_q, overflow_d;
    logic                    busy_q, busy_d;
    logic [MAX_ACTIVE-1:0]   slot_vld_q, slot_vld_d;
    logic [POS_W-1:0]        slot_x_q    [MAX_ACTIVE];
    logic [POS_W-1:0]        slot_x_d    [MAX_ACTIVE];
    logic [IDX_W-1:0]        slot_id_q   [MAX_ACTIVE];
    logic [IDX_W-1:0]        slot_id_d   [MAX_ACTIVE];
    logic [SPR_W-1:0]        slot_bits_q [MAX_ACTIVE];
    logic [SPR_W-1:0]        slot_bits_d [MAX_ACTIVE];
    logic                    pix_q, pix_d;
    logic                    drawing_q, drawing_d;
    logic [IDX_W-1:0]        sprite_id_q, sprite_id_d;

    logic [EXT_W-1:0]        cur_spy;
    logic [POS_W-1:0]        cur_spx;
    logic [ROW_W-1:0]        cur_row;
    logic                    cur_hit;
    logic                    last_idx;
    logic [MAX_ACTIVE-1:0]   slot_cov, slot_opq;

    // Hit test for the sprite under the scan index, widened so y+SPR_H cannot wrap
    always_comb begin
        cur_spy  = EXT_W'(spy_pos[int'(idx_q)*POS_W +: POS_W]);
        cur_spx  = spx_pos[int'(idx_q)*POS_W +: POS_W];
        cur_hit  = sprite_en[idx_q] && (target_q >= cur_spy) &&
                   (target_q < cur_spy + EXT_W'(SPR_H));
        cur_row  = ROW_W'(target_q - cur_spy);
        last_idx = (idx_q == IDX_W'(NUM_SPRITES - 1));
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        target_d    = target_q;
        rom_rd_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        overflow_d  = overflow_q;
        slot_vld_d  = slot_vld_q;
        slot_x_d    = slot_x_q;
        slot_id_d   = slot_id_q;
        slot_bits_d = slot_bits_q;

        // A new line always restarts, dropping any fetch still in flight
        if (line) begin
            target_d   = EXT_W'(vert_pos) + EXT_W'(1);
            slot_vld_d = '0;
            overflow_d = 1'b0;
            idx_d      = '0;
            fill_d     = '0;
            state_d    = SCAN;
        end else begin
            case (state_q)
                IDLE: ;
                SCAN: begin
                    if (cur_hit && (fill_q < FILL_W'(MAX_ACTIVE))) begin
                        rom_rd_d   = 1'b1;
                        rom_addr_d = ROM_AW'(int'(idx_q) * int'(SPR_H) + int'(cur_row));
                        state_d    = FETCH;
                    end else begin
                        if (cur_hit) overflow_d = 1'b1;
                        if (last_idx) state_d = IDLE;
                        else          idx_d   = idx_q + IDX_W'(1);
                    end
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    for (int s = 0; s < int'(MAX_ACTIVE); s++) begin
                        if (FILL_W'(s) == fill_q) begin
                            slot_vld_d[s]  = 1'b1;
                            slot_x_d[s]    = cur_spx;
                            slot_id_d[s]   = idx_q;
                            slot_bits_d[s] = rom_data;
                        end
                    end
                    fill_d = fill_q + FILL_W'(1);
                    if (last_idx) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SCAN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // Per-slot coverage and opacity; MSB of the row is the leftmost pixel
    always_comb begin
        for (int s = 0; s < int'(MAX_ACTIVE); s++) begin
            slot_cov[s] = slot_vld_q[s] &&
                          (EXT_W'(horiz_pos) >= EXT_W'(slot_x_q[s])) &&
                          (EXT_W'(horiz_pos) < EXT_W'(slot_x_q[s]) + EXT_W'(SPR_W));
            slot_opq[s] = slot_cov[s] &&
                          slot_bits_q[s][OFF_W'(SPR_W - 1) - OFF_W'(horiz_pos - slot_x_q[s])];
        end
    end

    always_comb begin
        sprite_id_d = '0;
        for (int s = int'(MAX_ACTIVE) - 1; s >= 0; s--) begin
            if (slot_opq[s]) sprite_id_d = slot_id_q[s];
        end
        pix_d     = |slot_opq;
        drawing_d = |slot_cov;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            fill_q      <= '0;
            target_q    <= '0;
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            slot_vld_q  <= '0;
            slot_x_q    <= '{default: '0};
            slot_id_q   <= '{default: '0};
            slot_bits_q <= '{default: '0};
            pix_q       <= 1'b0;
            drawing_q   <= 1'b0;
            sprite_id_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fill_q      <= fill_d;
            target_q    <= target_d;
            rom_rd_q    <= rom_rd_d;
            rom_addr_q  <= rom_addr_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            slot_vld_q  <= slot_vld_d;
            slot_x_q    <= slot_x_d;
            slot_id_q   <= slot_id_d;
            slot_bits_q <= slot_bits_d;
            pix_q       <= pix_d;
            drawing_q   <= drawing_d;
            sprite_id_q <= sprite_id_d;
        end
    end

    assign rom_rd    = rom_rd_q;
    assign rom_addr  = rom_addr_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
    assign pix       = pix_q;
    assign drawing   = drawing_q;
    assign sprite_id = sprite_id_q;

`ifdef SPRITE_COLLISION_EN
    logic collision_q, collision_d;
    logic collision_seen_q, collision_seen_d;

    // Sticky flag survives until the frame restarts at line 0
    always_comb begin
        collision_d = ($countones(slot_opq) >= 2);
        if (line && (vert_pos == '0)) collision_seen_d = 1'b0;
        else                          collision_seen_d = collision_seen_q | collision_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            collision_q      <= 1'b0;
            collision_seen_q <= 1'b0;
        end else begin
            collision_q      <= collision_d;
            collision_seen_q <= collision_seen_d;
        end
    end

    assign collision      = collision_q;
    assign collision_seen = collision_seen_q;
`endif

endmodule
